// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack clock-domain crossing with a one-word skid buffer.
// A word is launched by loading xfer_data and toggling xfer_req; it completes when the synchronized ack matches req.
module cdc_handshake_tx #(
    parameter int ARRAY_W = 9,
    parameter int DATA_W  = 12,
    parameter int SYNC_D  = 3
) (
    input  logic                           clk_sync_i,
    input  logic                           rst_i,
    input  logic [ARRAY_W-1:0][DATA_W-1:0] data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [ARRAY_W-1:0][DATA_W-1:0] xfer_data_o,
    output logic                           xfer_req_o,
    input  logic                           xfer_ack_i,
    output logic                           busy_o,
    output logic                           done_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                         state_reg, state_next;
    logic [ARRAY_W-1:0][DATA_W-1:0] xfer_data_reg, xfer_data_next;
    logic [ARRAY_W-1:0][DATA_W-1:0] pend_data_reg, pend_data_next;
    logic                           pend_full_reg, pend_full_next;
    logic                           req_reg, req_next;
    logic                           done_reg, done_next;
    logic [SYNC_D-1:0]              sync_reg;

    logic ack_s;
    logic accept;
    logic complete;

    assign ack_s    = sync_reg[SYNC_D-1];
    assign ready_o  = !pend_full_reg;
    assign accept   = valid_i && ready_o;
    // ack_s is only meaningful while a word is outstanding; IDLE ignores it.
    assign complete = (state_reg == WAIT_ACK) && (ack_s == req_reg);

    assign xfer_data_o = xfer_data_reg;
    assign xfer_req_o  = req_reg;
    assign busy_o      = (state_reg == WAIT_ACK);
    assign done_o      = done_reg;

    always_ff @(posedge clk_sync_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            xfer_data_reg <= '0;
            pend_data_reg <= '0;
            pend_full_reg <= 1'b0;
            req_reg       <= 1'b0;
            done_reg      <= 1'b0;
            sync_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            xfer_data_reg <= xfer_data_next;
            pend_data_reg <= pend_data_next;
            pend_full_reg <= pend_full_next;
            req_reg       <= req_next;
            done_reg      <= done_next;
            sync_reg      <= {sync_reg[SYNC_D-2:0], xfer_ack_i};
        end
    end

    always_comb begin
        state_next     = state_reg;
        xfer_data_next = xfer_data_reg;
        pend_data_next = pend_data_reg;
        pend_full_next = pend_full_reg;
        req_next       = req_reg;
        done_next      = complete;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    xfer_data_next = data_i;
                    req_next       = !req_reg;
                    state_next     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (complete) begin
                    // Pending word is older than data_i, so it launches first; ready_o is low then anyway.
                    if (pend_full_reg) begin
                        xfer_data_next = pend_data_reg;
                        req_next       = !req_reg;
                        pend_full_next = 1'b0;
                    end else if (accept) begin
                        xfer_data_next = data_i;
                        req_next       = !req_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept) begin
                    pend_data_next = data_i;
                    pend_full_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: a vector table walks single, back-to-back,
// accept-on-completion and spurious-ack cases; hand sequences cover reset behaviour.
module tb_cdc_handshake_tx;

    localparam int ARRAY_W = 9;
    localparam int DATA_W  = 12;
    localparam int SYNC_D  = 3;

    typedef logic [ARRAY_W-1:0][DATA_W-1:0] word_t;

    logic  clk_sync_i = 1'b0;
    logic  rst_i;
    word_t data_i;
    logic  valid_i;
    logic  ready_o;
    word_t xfer_data_o;
    logic  xfer_req_o;
    logic  xfer_ack_i;
    logic  busy_o;
    logic  done_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    cdc_handshake_tx #(
        .ARRAY_W(ARRAY_W),
        .DATA_W (DATA_W),
        .SYNC_D (SYNC_D)
    ) dut (
        .clk_sync_i (clk_sync_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .xfer_data_o(xfer_data_o),
        .xfer_req_o (xfer_req_o),
        .xfer_ack_i (xfer_ack_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_sync_i = !clk_sync_i;

    typedef struct {
        logic        valid;
        logic [11:0] d;
        logic        ack;
        logic        ready;
        logic        req;
        logic        busy;
        logic        done;
        logic [11:0] xd;
    } vec_t;

    vec_t tbl[$];

    function automatic word_t rep(input logic [11:0] v);
        word_t w;
        for (int i = 0; i < ARRAY_W; i++) w[i] = v;
        return w;
    endfunction

    function automatic void add(input logic v, input logic [11:0] d, input logic a,
                                input logic rdy, input logic rq, input logic bz,
                                input logic dn, input logic [11:0] xd);
        vec_t e;
        e.valid = v; e.d = d; e.ack = a;
        e.ready = rdy; e.req = rq; e.busy = bz; e.done = dn; e.xd = xd;
        tbl.push_back(e);
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input word_t act, input word_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic rq, input logic bz,
                           input logic dn, input word_t xd);
        chk_bit({tag, " ready"}, ready_o, rdy);
        chk_bit({tag, " req"}, xfer_req_o, rq);
        chk_bit({tag, " busy"}, busy_o, bz);
        chk_bit({tag, " done"}, done_o, dn);
        chk_word({tag, " data"}, xfer_data_o, xd);
    endtask

    task automatic tick();
        @(posedge clk_sync_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        data_i     = '0;
        xfer_ack_i = 1'b0;

        //   v  data     ack rdy req bsy dn  xfer_data
        add(1, 12'hA5A, 0,  1,  1,  1,  0, 12'hA5A); // 0 single launch
        add(0, 12'h0F0, 1,  1,  1,  1,  0, 12'hA5A); // 1 ack toggles, data_i wiggles
        add(0, 12'hF0F, 1,  1,  1,  1,  0, 12'hA5A);
        add(0, 12'h123, 1,  1,  1,  1,  0, 12'hA5A);
        add(0, 12'h321, 1,  1,  1,  0,  1, 12'hA5A); // 4 done SYNC_D+1 edges after ack
        add(0, 12'h000, 1,  1,  1,  0,  0, 12'hA5A);
        add(1, 12'h111, 1,  1,  0,  1,  0, 12'h111); // 6 W1
        add(1, 12'h222, 1,  0,  0,  1,  0, 12'h111); // 7 W2 pending
        add(1, 12'h333, 0,  0,  0,  1,  0, 12'h111); // 8 refused, ack W1
        add(0, 12'h333, 0,  0,  0,  1,  0, 12'h111);
        add(0, 12'h333, 0,  0,  0,  1,  0, 12'h111);
        add(0, 12'h333, 0,  1,  1,  1,  1, 12'h222); // 11 W2 launches from pending
        add(0, 12'h000, 1,  1,  1,  1,  0, 12'h222);
        add(0, 12'h000, 1,  1,  1,  1,  0, 12'h222);
        add(0, 12'h000, 1,  1,  1,  1,  0, 12'h222);
        add(1, 12'h444, 1,  1,  0,  1,  1, 12'h444); // 15 accept on completion
        add(0, 12'h000, 1,  1,  0,  1,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  1,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  1,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  1,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  0,  1, 12'h444); // 20 back to IDLE
        add(0, 12'h000, 0,  1,  0,  0,  0, 12'h444);
        add(0, 12'h000, 1,  1,  0,  0,  0, 12'h444); // 22 spurious ack pulse
        add(0, 12'h000, 1,  1,  0,  0,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  0,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  0,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  0,  0, 12'h444);
        add(0, 12'h000, 0,  1,  0,  0,  0, 12'h444);
        add(1, 12'h555, 0,  1,  1,  1,  0, 12'h555); // 28 normal launch after spurious
        add(0, 12'h000, 0,  1,  1,  1,  0, 12'h555);

        tick();
        tick();
        chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        $display("reset: ready=%b req=%b busy=%b done=%b", ready_o, xfer_req_o, busy_o, done_o);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            valid_i    = tbl[i].valid;
            data_i     = rep(tbl[i].d);
            xfer_ack_i = tbl[i].ack;
            tick();
            $display("vec %0d: v=%b d=%h ack=%b -> ready=%b req=%b busy=%b done=%b xd0=%h",
                     i, tbl[i].valid, tbl[i].d, tbl[i].ack, ready_o, xfer_req_o, busy_o,
                     done_o, xfer_data_o[0]);
            chk_all($sformatf("vec%0d", i), tbl[i].ready, tbl[i].req, tbl[i].busy,
                    tbl[i].done, rep(tbl[i].xd));
        end

        // Fill pending, then reset mid-transfer.
        valid_i = 1'b1;
        data_i  = rep(12'h666);
        tick();
        chk_bit("pend fill ready", ready_o, 1'b0);
        chk_word("pend fill data", xfer_data_o, rep(12'h555));
        $display("pend fill: ready=%b busy=%b", ready_o, busy_o);
        valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("async rst", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        $display("async rst: ready=%b req=%b busy=%b done=%b", ready_o, xfer_req_o, busy_o, done_o);
        xfer_ack_i = 1'b0;
        tick();
        chk_all("rst hold", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #3;
        rst_i = 1'b0;
        tick();
        chk_all("post rst", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        $display("post rst: ready=%b req=%b busy=%b done=%b", ready_o, xfer_req_o, busy_o, done_o);

        valid_i = 1'b1;
        data_i  = rep(12'h777);
        tick();
        chk_all("first after rst", 1'b1, 1'b1, 1'b1, 1'b0, rep(12'h777));
        $display("first after rst: req=%b busy=%b xd0=%h", xfer_req_o, busy_o, xfer_data_o[0]);
        valid_i = 1'b0;
        tick();
        chk_all("hold after rst", 1'b1, 1'b1, 1'b1, 1'b0, rep(12'h777));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
